cart_mem_req: RTL and testbench



---
 rtl/cart_mem_req.sv | 129 ++++++++++++
 tb/tb_cart_mem_req.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cart_mem_req.sv
// Turns mapper-qualified CPU reads/writes into single SDRAM requests, stalling the Z80 until ack or timeout.
// Optional one-entry read cache when CART_MEM_CACHE_EN is defined.
module cart_mem_req #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [24:0] mem_addr,
  input  logic        mem_oe,
  input  logic        mem_we,
  input  logic [7:0]  d_from_cpu,
  output logic [7:0]  d_to_cpu,
  output logic        wait_n,
  output logic        sdram_req,
  output logic        sdram_we,
  output logic [24:0] sdram_addr,
  output logic [7:0]  sdram_din,
  input  logic        sdram_ack,
  input  logic [7:0]  sdram_dout,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  // Counter holds the number of REQ cycles already completed, so the last allowed cycle is TIMEOUT-1.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        rd_q, wr_q;
  logic        rd_start, wr_start, start;
  logic        is_wr;
  logic        hit;
  logic        to_hit;
  logic [7:0]  cnt;

  assign rd_start = rd & mem_oe & ~rd_q;
  assign wr_start = wr & mem_we & ~wr_q;
  assign start    = rd_start | wr_start;
  assign to_hit   = (cnt == TO_LAST);

`ifdef CART_MEM_CACHE_EN
  logic        c_valid;
  logic [24:0] c_tag;
  logic [7:0]  c_data;

  assign hit = rd_start & ~wr_start & c_valid & (c_tag == mem_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_valid <= 1'b0;
      c_tag   <= '0;
      c_data  <= '0;
    end else if (state == REQ) begin
      if (sdram_ack) begin
        if (!is_wr) begin
          c_valid <= 1'b1;
          c_tag   <= sdram_addr;
          c_data  <= sdram_dout;
        end else if (c_valid && c_tag == sdram_addr) begin
          c_data  <= sdram_din;
        end
      end else if (to_hit) begin
        c_valid <= 1'b0;
      end
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = hit ? HOLD : REQ;
      REQ:  if (sdram_ack || to_hit) state_nxt = HOLD;
      HOLD: if (is_wr ? (!wr && !wr_q) : (!rd && !rd_q)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wait_n = ~(((state == IDLE) & start & ~hit) | (state == REQ));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      sdram_req   <= 1'b0;
      sdram_we    <= 1'b0;
      sdram_addr  <= '0;
      sdram_din   <= '0;
      is_wr       <= 1'b0;
      cnt         <= '0;
      d_to_cpu    <= 8'hFF;
      timeout_err <= 1'b0;
    end else begin
      rd_q      <= rd;
      wr_q      <= wr;
      sdram_req <= (state_nxt == REQ);
      cnt       <= (state == REQ) ? cnt + 8'd1 : 8'd0;
      if (state == IDLE && start) begin
        sdram_addr <= mem_addr;
        sdram_din  <= d_from_cpu;
        sdram_we   <= wr_start;
        is_wr      <= wr_start;
      end
`ifdef CART_MEM_CACHE_EN
      if (state == IDLE && hit) d_to_cpu <= c_data;
`endif
      if (state == REQ) begin
        if (sdram_ack) begin
          if (!is_wr) d_to_cpu <= sdram_dout;
        end else if (to_hit) begin
          d_to_cpu    <= 8'hFF;
          timeout_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cart_mem_req.sv
// Randomized self-checking bench for cart_mem_req against a per-access behavioural model.
module tb_cart_mem_req;
  localparam int TIMEOUT = 8;

  logic        clk, reset;
  logic        rd, wr, mem_oe, mem_we;
  logic [24:0] mem_addr;
  logic [7:0]  d_from_cpu, d_to_cpu, sdram_din, sdram_dout;
  logic        wait_n, sdram_req, sdram_we, sdram_ack, timeout_err;
  logic [24:0] sdram_addr;

  int checks = 0;
  int failures = 0;

  // Model state
  logic [7:0]  m_d = 8'hFF;
  logic        m_err = 1'b0;
  logic        c_valid = 1'b0;
  logic [24:0] c_tag = '0;
  logic [7:0]  c_data = '0;

  cart_mem_req #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .mem_addr(mem_addr),
    .mem_oe(mem_oe), .mem_we(mem_we), .d_from_cpu(d_from_cpu),
    .d_to_cpu(d_to_cpu), .wait_n(wait_n), .sdram_req(sdram_req),
    .sdram_we(sdram_we), .sdram_addr(sdram_addr), .sdram_din(sdram_din),
    .sdram_ack(sdram_ack), .sdram_dout(sdram_dout), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One CPU access: strobe in cycle 0, ack pulse in cycle n (n > TIMEOUT means it arrives too late).
  task automatic do_access(input bit w, input logic [24:0] a, input logic [7:0] d,
                           input int n, input logic [7:0] dout);
    bit hitm, acked, exp_req, exp_wait;
    int endc, last;
    hitm = 1'b0;
`ifdef CART_MEM_CACHE_EN
    hitm = !w && c_valid && (c_tag == a);
`endif
    acked = !hitm && (n <= TIMEOUT);
    endc  = hitm ? 0 : (acked ? n : TIMEOUT);
    last  = (n > endc + 1) ? n : endc + 1;
    for (int c = 0; c <= last; c++) begin
      if (c == 0) begin
        rd = !w; wr = w; mem_oe = 1'b1; mem_we = w; mem_addr = a; d_from_cpu = d;
      end else begin
        mem_addr = 25'($urandom); d_from_cpu = 8'($urandom);
      end
      sdram_ack  = (c == n);
      sdram_dout = (c == n) ? dout : 8'($urandom);
      #1;
      if (c == endc + 1) begin
        if (hitm) m_d = c_data;
        else if (acked) begin
          if (!w) begin m_d = dout; c_valid = 1'b1; c_tag = a; c_data = dout; end
          else if (c_valid && c_tag == a) c_data = d;
        end else begin
          m_d = 8'hFF; m_err = 1'b1; c_valid = 1'b0;
        end
      end
      exp_req  = !hitm && c >= 1 && c <= endc;
      exp_wait = !(!hitm && c <= endc);
      checks++;
      if (sdram_req !== exp_req) begin
        failures++; $display("FAIL req c=%0d got=%b exp=%b", c, sdram_req, exp_req);
      end
      checks++;
      if (wait_n !== exp_wait) begin
        failures++; $display("FAIL wait_n c=%0d got=%b exp=%b", c, wait_n, exp_wait);
      end
      checks++;
      if (d_to_cpu !== m_d) begin
        failures++; $display("FAIL d_to_cpu c=%0d got=%h exp=%h", c, d_to_cpu, m_d);
      end
      checks++;
      if (timeout_err !== m_err) begin
        failures++; $display("FAIL timeout_err c=%0d got=%b exp=%b", c, timeout_err, m_err);
      end
      if (exp_req) begin
        checks++;
        if (sdram_addr !== a || sdram_we !== w || sdram_din !== d) begin
          failures++;
          $display("FAIL latch c=%0d got=%h/%b/%h exp=%h/%b/%h", c, sdram_addr, sdram_we, sdram_din, a, w, d);
        end
      end
      tick();
    end
    rd = 1'b0; wr = 1'b0; sdram_ack = 1'b0;
    tick();
    tick();
    checks++;
    if (sdram_req !== 1'b0 || wait_n !== 1'b1) begin
      failures++; $display("FAIL idle_after got req=%b wait_n=%b exp req=0 wait_n=1", sdram_req, wait_n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rd = 0; wr = 0; mem_oe = 0; mem_we = 0; mem_addr = '0;
    d_from_cpu = '0; sdram_ack = 0; sdram_dout = '0;
    #3;
    checks++;
    if (sdram_req !== 0 || sdram_we !== 0 || sdram_addr !== '0 || sdram_din !== '0) begin
      failures++;
      $display("FAIL reset_sdram got req=%b we=%b addr=%h din=%h exp all 0", sdram_req, sdram_we, sdram_addr, sdram_din);
    end
    checks++;
    if (d_to_cpu !== 8'hFF || timeout_err !== 0 || wait_n !== 1) begin
      failures++;
      $display("FAIL reset_cpu got d=%h err=%b wait_n=%b exp FF/0/1", d_to_cpu, timeout_err, wait_n);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read();
    do_access(1'b0, 25'h0001234, 8'h00, 3, 8'h5A);
    checks++;
    if (d_to_cpu !== 8'h5A) begin
      failures++; $display("FAIL read_5a got=%h exp=5a", d_to_cpu);
    end
  endtask

  task automatic test_write();
    do_access(1'b1, 25'h0012345, 8'hC3, 4, 8'h00);
    do_access(1'b1, 25'h1FFFFFF, 8'h3C, 1, 8'h00);
  endtask

  task automatic test_no_select();
    for (int c = 0; c < 4; c++) begin
      rd = 1'b1; wr = (c >= 2); mem_oe = 1'b0; mem_we = 1'b0; mem_addr = 25'($urandom);
      #1;
      checks++;
      if (sdram_req !== 1'b0 || wait_n !== 1'b1) begin
        failures++; $display("FAIL no_select c=%0d got req=%b wait_n=%b exp req=0 wait_n=1", c, sdram_req, wait_n);
      end
      tick();
    end
    rd = 1'b0; wr = 1'b0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    do_access(1'b0, 25'h0000777, 8'h00, TIMEOUT + 3, 8'h12);
    checks++;
    if (d_to_cpu !== 8'hFF || timeout_err !== 1'b1) begin
      failures++; $display("FAIL timeout got d=%h err=%b exp FF/1", d_to_cpu, timeout_err);
    end
  endtask

  task automatic test_cache();
`ifdef CART_MEM_CACHE_EN
    do_access(1'b0, 25'h0004000, 8'h00, 2, 8'h77);
    do_access(1'b0, 25'h0004000, 8'h00, 2, 8'h11);
    checks++;
    if (d_to_cpu !== 8'h77) begin
      failures++; $display("FAIL cache_hit got=%h exp=77", d_to_cpu);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_access(1'($urandom), 25'(32'h4000 + $urandom_range(0, 3)), 8'($urandom),
                $urandom_range(1, TIMEOUT + 2), 8'($urandom));
    end
  endtask

  task automatic test_reset_mid_req();
    rd = 1'b1; mem_oe = 1'b1; mem_addr = 25'h0000ABC;
    tick(); tick();
    rd = 1'b0; reset = 1'b1;
    #1;
    checks++;
    if (sdram_req !== 1'b0 || wait_n !== 1'b1 || d_to_cpu !== 8'hFF) begin
      failures++;
      $display("FAIL reset_mid got req=%b wait_n=%b d=%h exp 0/1/FF", sdram_req, wait_n, d_to_cpu);
    end
    m_d = 8'hFF; m_err = 1'b0; c_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    sdram_ack = 1'b1; sdram_dout = 8'h42;
    tick();
    sdram_ack = 1'b0;
    tick();
    checks++;
    if (d_to_cpu !== 8'hFF || sdram_req !== 1'b0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL late_ack got d=%h req=%b err=%b exp FF/0/0", d_to_cpu, sdram_req, timeout_err);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_no_select();
    test_timeout();
    test_cache();
    test_random();
    test_reset_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
